// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue between the PC stage and decode
//
// Issues the current fetch address over a req/gnt memory channel, tracks
// accepted-but-unanswered requests, collects in-order responses into an
// instruction FIFO and hands instruction + address to decode (valid/ready).
// A redirect (flush) empties the FIFO and marks every outstanding request for
// discard, so stale responses drain without reaching decode.
//
// Optional feature: define IFETCH_QUEUE_BYPASS_EN to forward a response
// straight to decode in the same cycle when the FIFO is empty.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   pc           fetch address from the PC stage
//   flush        redirect; kills queued and in-flight fetches
//   pc_stall     pc was not accepted this cycle, PC stage must hold
//   imem_req     fetch request valid
//   imem_addr    fetch address (equals pc)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  in-order response valid
//   imem_rdata   instruction word of the response
//   inst_valid   instruction available to decode
//   inst         instruction word at FIFO head
//   inst_pc      address of inst
//   inst_ready   decode consumes the head this cycle

module ifetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [OW-1:0] ONE_O = OW'(1);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    logic [OW-1:0] out_cnt;
    logic [OW-1:0] discard_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];

    // Address queue: remembers the pc of every accepted request so that the
    // in-order response can be tagged with its address.
    logic [AW-1:0] aq_rd;
    logic [AW-1:0] aq_wr;
    logic [31:0]   aq_mem [MAX_OUT];

    logic          accept;
    logic          resp;
    logic          keep;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [31:0]   resp_addr;
    logic [31:0]   reserved;

    function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
        return (32'(p) == 32'(MAX_OUT - 1)) ? '0 : p + AW'(1);
    endfunction

    // Slots already spoken for: entries in the FIFO plus responses still to
    // come that will land there (outstanding minus those marked for discard).
    // Issuing only while this is below DEPTH means the FIFO can never overflow.
    assign reserved   = 32'(fifo_cnt) + 32'(out_cnt) - 32'(discard_cnt);

    assign imem_req   = reset & ~flush & (32'(out_cnt) < 32'(MAX_OUT)) &
                        (reserved < 32'(DEPTH));
    assign imem_addr  = pc;
    assign accept     = imem_req & imem_gnt;
    assign pc_stall   = ~accept;

    // A response with nothing outstanding is a protocol violation: ignore it.
    assign resp       = imem_rvalid & (out_cnt != '0);
    // A response arriving in the flush cycle belongs to the old path.
    assign keep       = resp & (discard_cnt == '0) & ~flush;
    assign resp_addr  = aq_mem[aq_rd];
    assign fifo_empty = (fifo_cnt == '0);

`ifdef IFETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = keep & fifo_empty;

    always_comb begin
        inst_valid = (~fifo_empty & ~flush) | bypass;
        inst       = fifo_data[rd_ptr];
        inst_pc    = fifo_addr[rd_ptr];
        if (bypass) begin
            inst    = imem_rdata;
            inst_pc = resp_addr;
        end
    end

    // Bypass only happens with an empty FIFO, so it never overlaps a pop.
    assign fifo_pop  = ~fifo_empty & ~flush & inst_ready;
    assign fifo_push = keep & ~(bypass & inst_ready);
`else
    always_comb begin
        inst_valid = ~fifo_empty & ~flush;
        inst       = fifo_data[rd_ptr];
        inst_pc    = fifo_addr[rd_ptr];
    end

    assign fifo_pop  = inst_valid & inst_ready;
    assign fifo_push = keep;
`endif

    // Outstanding-request and discard bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt     <= '0;
            discard_cnt <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            case ({accept, resp})
                2'b10:   out_cnt <= out_cnt + ONE_O;
                2'b01:   out_cnt <= out_cnt - ONE_O;
                default: out_cnt <= out_cnt;
            endcase

            // No request is issued during flush, so everything still
            // outstanding afterwards is old-path and must be dropped.
            if (flush) begin
                discard_cnt <= out_cnt - OW'(resp);
            end else if (resp && (discard_cnt != '0)) begin
                discard_cnt <= discard_cnt - ONE_O;
            end

            // The address queue is not cleared on flush: discarded responses
            // still have to pop their entries in order.
            if (accept) begin
                aq_wr <= aq_next(aq_wr);
            end
            if (resp) begin
                aq_rd <= aq_next(aq_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            aq_mem[aq_wr] <= pc;
        end
    end

    // Instruction FIFO control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (flush) begin
            fifo_cnt <= '0;
            rd_ptr   <= wr_ptr;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + ONE_C;
                2'b01:   fifo_cnt <= fifo_cnt - ONE_C;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_addr[wr_ptr] <= resp_addr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue

module tb_ifetch_queue;

    localparam logic [31:0] K = 32'hC0DE_0000;   // memory word = address ^ K

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    int          n_cons = 0;
    bit          resp_en = 1'b0;
    logic [31:0] pend [$];
    logic [31:0] expq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_mem();
        imem_rvalid = resp_en && (pend.size() > 0);
        imem_rdata  = (pend.size() > 0) ? (pend[0] ^ K) : 32'h0;
    endtask

    // One clock: bookkeeping at the negedge, then next-cycle inputs after posedge.
    task automatic cyc();
        logic        acc;
        logic [31:0] e;
        logic [31:0] tmp;
        @(negedge clk);
        acc = imem_req & imem_gnt;
        if (imem_rvalid && (pend.size() > 0)) tmp = pend.pop_front();
        if (acc) begin
            pend.push_back(pc);
            n_acc++;
        end
        if (inst_valid && inst_ready) begin
            n_cons++;
            if (expq.size() == 0) begin
                check("extra_inst_pc", inst_pc, 32'hFFFF_FFFC);
            end else begin
                e = expq.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst", inst, e ^ K);
            end
        end
        @(posedge clk);
        #1;
        if (acc) pc = pc + 32'd4;
        drive_mem();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; imem_gnt = 1'b0; inst_ready = 1'b0;
        resp_en = 1'b0; pc = 32'h0;
        pend.delete();
        expq.delete();
        drive_mem();
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_stall", 32'(pc_stall), 32'd1);
        cyc();
        cyc();
        n_acc  = 0;
        n_cons = 0;
    endtask

    task automatic flush_case(input logic [31:0] tgt, input bit rv_in_flush);
        int lat;
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1; resp_en = 1'b1; pc = 32'h0;
        drive_mem();
        #1;
        cyc();                  // accept 0x0
        cyc();                  // accept 0x4, response 0x0
        resp_en = 1'b0;
        cyc();                  // accept 0x8, response 0x4; memory then stalls
        cyc();                  // accept 0xC; 0x8 and 0xC outstanding
        check("fl_pre_valid", 32'(inst_valid), 32'd1);
        check("fl_pre_req", 32'(imem_req), 32'd0);
        flush = 1'b1; pc = tgt; inst_ready = 1'b1; resp_en = rv_in_flush;
        drive_mem();
        #1;
        check("fl_valid", 32'(inst_valid), 32'd0);
        check("fl_stall", 32'(pc_stall), 32'd1);
        check("fl_req", 32'(imem_req), 32'd0);
        cyc();
        flush = 1'b0; resp_en = 1'b1;
        drive_mem();
        #1;
        expq.push_back(tgt);
        expq.push_back(tgt + 32'd4);
        check("fl_k1_req", 32'(imem_req), rv_in_flush ? 32'd1 : 32'd0);
        lat = rv_in_flush ? 3 : 4;
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                check("fl_drop_valid", 32'(inst_valid), 32'd0);
            end else begin
                check("fl_first_valid", 32'(inst_valid), 32'd1);
                check("fl_first_pc", inst_pc, tgt);
            end
            cyc();
        end
        check("fl_cons", 32'(n_cons), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pc = 32'h0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;

        // Streaming with a 1-cycle memory
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; resp_en = 1'b1; pc = 32'h0;
        drive_mem();
        #1;
        for (int i = 0; i < 8; i++) expq.push_back(32'(i * 4));
        check("s1_c0_req", 32'(imem_req), 32'd1);
        check("s1_c0_valid", 32'(inst_valid), 32'd0);
        for (int c = 0; c < 10; c++) begin
            check("s1_stall", 32'(pc_stall), 32'd0);
            if (c == 1) check("s1_c1_valid", 32'(inst_valid), 32'd0);
            if (c == 2) begin
                check("s1_c2_valid", 32'(inst_valid), 32'd1);
                check("s1_c2_pc", inst_pc, 32'h0);
            end
            cyc();
        end
        check("s1_cons", 32'(n_cons), 32'd8);

        // Backpressure: decode not ready
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1; resp_en = 1'b1; pc = 32'h0;
        drive_mem();
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) begin
                check("s2_full_req", 32'(imem_req), 32'd0);
                check("s2_full_stall", 32'(pc_stall), 32'd1);
            end
            cyc();
        end
        check("s2_acc", 32'(n_acc), 32'd4);
        check("s2_hold_req", 32'(imem_req), 32'd0);
        check("s2_hold_addr", imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) expq.push_back(32'(i * 4));
        inst_ready = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                check("s2_resume_req", 32'(imem_req), 32'd1);
                check("s2_resume_addr", imem_addr, 32'h10);
            end
            cyc();
        end
        check("s2_cons", 32'(n_cons), 32'd5);

        // Flush with two requests in flight, then flush coinciding with a response
        flush_case(32'h100, 1'b0);
        flush_case(32'h200, 1'b1);

        // Reset pulse with two outstanding requests
        do_reset();
        reset = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; resp_en = 1'b0; pc = 32'h0;
        drive_mem();
        #1;
        cyc();
        cyc();
        check("rs_pre_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        #1;
        check("rs_valid", 32'(inst_valid), 32'd0);
        check("rs_req", 32'(imem_req), 32'd0);
        check("rs_stall", 32'(pc_stall), 32'd1);
        cyc();
        reset = 1'b1; imem_gnt = 1'b0; resp_en = 1'b1; pc = 32'h300;
        n_acc = 0; n_cons = 0;
        expq.push_back(32'h300);
        drive_mem();
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rs_stray_rvalid", 32'(imem_rvalid), 32'd1);
            check("rs_stray_valid", 32'(inst_valid), 32'd0);
            cyc();
        end
        imem_gnt = 1'b1;
        #1;
        for (int k = 2; k <= 4; k++) begin
            if (k < 4) begin
                check("rs_wait_valid", 32'(inst_valid), 32'd0);
            end else begin
                check("rs_first_valid", 32'(inst_valid), 32'd1);
                check("rs_first_pc", inst_pc, 32'h300);
            end
            cyc();
        end
        check("rs_cons", 32'(n_cons), 32'd1);

        // Grant stalls at pc=0x40
        do_reset();
        reset = 1'b1; imem_gnt = 1'b0; inst_ready = 1'b1; resp_en = 1'b1; pc = 32'h40;
        drive_mem();
        #1;
        expq.push_back(32'h40);
        for (int k = 0; k < 3; k++) begin
            check("gs_stall", 32'(pc_stall), 32'd1);
            check("gs_addr", imem_addr, 32'h40);
            check("gs_req", 32'(imem_req), 32'd1);
            cyc();
        end
        imem_gnt = 1'b1;
        #1;
        check("gs_accept_stall", 32'(pc_stall), 32'd0);
        cyc();
        imem_gnt = 1'b0;
        #1;
        check("gs_resp_valid", 32'(inst_valid), 32'd0);
        cyc();
        check("gs_out_valid", 32'(inst_valid), 32'd1);
        check("gs_out_pc", inst_pc, 32'h40);
        cyc();
        check("gs_after_valid", 32'(inst_valid), 32'd0);
        cyc();
        check("gs_acc", 32'(n_acc), 32'd1);
        check("gs_cons", 32'(n_cons), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
